rf_wr_arb: RTL

Write-port arbiter for the 32×32-bit register file `rf`. It shares the single write port (`we`/`rw`/`rd`) between two writeback requesters:
- Port A: ALU writeback, normally given priority.
- Port B: memory/load writeback, protected from starvation by a counter.

Each accepted request is registered and presented to `rf` one cycle later. The block sits between the pipeline writeback stage and `rf`.

---
 rtl/rf_wr_arb.sv | 82 ++++++++
 1 files changed

// File: rtl/rf_wr_arb.sv
// Two-requester write-port arbiter for the register file: A has priority, B is starvation-protected.
// Optional: define RF_WR_ARB_R0_FILTER_EN to suppress writes to register 0.
module rf_wr_arb #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic          we,
    output logic [AW-1:0] rw,
    output logic [DW-1:0] rd,
    output logic          b_forced
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0]    starve_cnt;
    logic          blk;
    logic          frc;
    logic          ga;
    logic          gb;
    logic          b_xfer;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    // Grant terms are made mutually exclusive so priority is explicit.
    always_comb begin
        blk    = rst | hold;
        frc    = !blk && b_valid && (starve_cnt == SMAX);
        ga     = !blk && !frc && a_valid;
        gb     = !blk && !frc && !a_valid && b_valid;
        b_xfer = frc | gb;
        waddr  = ga ? a_addr : b_addr;
        wdata  = ga ? a_data : b_data;
`ifdef RF_WR_ARB_R0_FILTER_EN
        wen    = (ga | b_xfer) && (waddr != '0);
`else
        wen    = ga | b_xfer;
`endif
    end

    assign a_ready = ga;
    assign b_ready = b_xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (b_xfer) begin
            starve_cnt <= '0;
        end else if (b_valid && !hold && starve_cnt < SMAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we       <= 1'b0;
            rw       <= '0;
            rd       <= '0;
            b_forced <= 1'b0;
        end else begin
            we       <= wen;
            b_forced <= frc;
            if (wen) begin
                rw <= waddr;
                rd <= wdata;
            end
        end
    end

endmodule
